// File: rtl/wbsample_if.sv
// Wishbone bus bundle between the command-bus initiator and the sample responder.
interface wbsample_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wbsample.sv
// Wishbone responder with a small control/status register bank and a sample FIFO
// that the host drains through the DATA register. Every selected cycle gets a
// registered single-cycle ack; side effects commit on the acking edge only.
module wbsample #(
    parameter logic [15:0] BASE_ADR   = 16'h0100,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  ID_VALUE   = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    wbsample_if.slave  wb,
    input  logic       smp_valid,
    input  logic [7:0] smp_data,
    output logic       irq_o
);
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                  ack_q, ack_d;
    logic [7:0]            dat_q, dat_d;
    logic                  irq_q, irq_d;
    logic                  cap_en_q, cap_en_d;
    logic                  irq_en_q, irq_en_d;
    logic [7:0]            scratch_q, scratch_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            mem_q [DEPTH];

    logic       sel, access, wr_acc, rd_acc;
    logic [3:0] offset;
    logic       empty, full, push, pop, clear, w1c, ovf_set;
    logic [7:0] rd_val;

    // Decode the bus cycle; an access is a selected cycle not already being acked,
    // so a strobe held through its ack cycle is not executed twice.
    always_comb begin
        sel     = wb.wb_stb_i && wb.wb_cyc_i && (wb.wb_adr_i[15:4] == BASE_ADR[15:4]);
        access  = sel && !ack_q;
        offset  = wb.wb_adr_i[3:0];
        wr_acc  = access && wb.wb_we_i;
        rd_acc  = access && !wb.wb_we_i;
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        clear   = wr_acc && (offset == 4'd1) && wb.wb_dat_i[2];
        w1c     = wr_acc && (offset == 4'd2) && wb.wb_dat_i[2];
        pop     = rd_acc && (offset == 4'd4) && !empty && !clear;
        push    = smp_valid && cap_en_q && (!full || pop) && !clear;
        ovf_set = smp_valid && cap_en_q && full && !pop && !clear;
    end

    // Read mux for the register bank; unmapped offsets and empty DATA read zero.
    always_comb begin
        rd_val = 8'h00;
        case (offset)
            4'd0:    rd_val = ID_VALUE;
            4'd1:    rd_val = {6'b0, irq_en_q, cap_en_q};
            4'd2:    rd_val = {5'b0, ovf_q, full, empty};
            4'd3:    rd_val = 8'(count_q);
            4'd4:    rd_val = empty ? 8'h00 : mem_q[rd_ptr_q];
            4'd5:    rd_val = scratch_q;
            default: rd_val = 8'h00;
        endcase
    end

    // Next-state for bus response, control registers, sticky overflow and FIFO pointers.
    always_comb begin
        ack_d     = access;
        dat_d     = access ? rd_val : 8'h00;
        irq_d     = irq_en_q && !empty;
        cap_en_d  = cap_en_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (wr_acc && offset == 4'd1) begin
            cap_en_d = wb.wb_dat_i[0];
            irq_en_d = wb.wb_dat_i[1];
        end
        if (wr_acc && offset == 4'd5) begin
            scratch_d = wb.wb_dat_i;
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (w1c) begin
            ovf_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            dat_q     <= 8'h00;
            irq_q     <= 1'b0;
            cap_en_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            scratch_q <= 8'h00;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            cap_en_q  <= cap_en_d;
            irq_en_q  <= irq_en_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Sample storage; no reset needed since only occupied entries are ever read.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= smp_data;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = irq_q;
endmodule
